// File: rtl/mcu_spi_responder.sv
// SPI mode-0 responder: oversampled MCU frame -> single core-bus write, four-phase req/ack.
// Define MCU_SPI_CRC_EN to require a trailing CRC-8 byte over cmd+data.
module mcu_spi_responder #(
    parameter int          DATA_BYTES  = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0500_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    input  logic                    mcu_req,
    output logic                    mcu_ack,
    output logic                    wr_valid,
    output logic [31:0]             wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    input  logic                    wr_ready,
    output logic                    frame_err,
    output logic [7:0]              err_count
);
`ifdef MCU_SPI_CRC_EN
    localparam int CRC_BYTES = 1;
`else
    localparam int CRC_BYTES = 0;
`endif
    localparam int NB  = DATA_BYTES + 1 + CRC_BYTES;
    localparam int SW  = 8 * NB;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int BCW = $clog2(NB + 1);

    typedef enum logic [2:0] {IDLE, ARMED, SHIFT, COMMIT, DONE} state_t;

    // sync lanes: [3]=req [2]=mosi [1]=cs_n [0]=sclk
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] in_s;
    logic       sclk_last_q, cs_last_q;
    logic       sclk_rise_q, cs_fall_q, cs_rise_q, mosi_q;

    assign in_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
            sclk_last_q <= 1'b0;
            cs_last_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sync_q[0] <= {mcu_req, spi_mosi, spi_cs_n, spi_sclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_last_q <= in_s[0];
            cs_last_q   <= in_s[1];
            sclk_rise_q <= in_s[0] & ~sclk_last_q;
            cs_fall_q   <= ~in_s[1] & cs_last_q;
            cs_rise_q   <= in_s[1] & ~cs_last_q;
            mosi_q      <= in_s[2];
        end
    end

    state_t         state_q;
    logic [2:0]     bit_cnt_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [SW-1:0]  shift_q;
    logic [7:0]     cmd;
    logic           frame_ok;
    logic           req_s;

    assign req_s = in_s[3];
    assign cmd   = shift_q[SW-1 -: 8];

`ifdef MCU_SPI_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_d;
    assign crc_d = {crc_q[6:0], 1'b0} ^ ({8{crc_q[7] ^ mosi_q}} & 8'h07);
`endif

    always_comb begin
        frame_ok = (byte_cnt_q == BCW'(NB)) && cmd[7];
`ifdef MCU_SPI_CRC_EN
        frame_ok = frame_ok && (crc_q == shift_q[7:0]);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            mcu_ack    <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
`ifdef MCU_SPI_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        state_q <= ARMED;
                        mcu_ack <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                        mcu_ack <= 1'b0;
                    end else if (cs_fall_q) begin
                        state_q    <= SHIFT;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        shift_q    <= '0;
`ifdef MCU_SPI_CRC_EN
                        crc_q      <= '0;
`endif
                    end
                end
                SHIFT: begin
                    // cs_n rise takes priority over a coincident sclk rise
                    if (cs_rise_q) begin
                        if (frame_ok) begin
                            state_q  <= COMMIT;
                            wr_valid <= 1'b1;
                            wr_addr  <= ADDR_BASE + {23'b0, cmd[6:0], 2'b00};
                            wr_data  <= shift_q[SW-9 -: DW];
                        end else begin
                            state_q   <= ARMED;
                            frame_err <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                    end else if (sclk_rise_q && byte_cnt_q != BCW'(NB)) begin
                        shift_q   <= {shift_q[SW-2:0], mosi_q};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_cnt_q <= byte_cnt_q + 1'b1;
`ifdef MCU_SPI_CRC_EN
                        if (byte_cnt_q < BCW'(NB - 1)) crc_q <= crc_d;
`endif
                    end
                end
                COMMIT: begin
                    if (wr_ready) begin
                        state_q  <= DONE;
                        wr_valid <= 1'b0;
                        mcu_ack  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!req_s) state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    mcu_ack  <= 1'b0;
                    wr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_spi_responder.sv
// Randomized self-checking bench for mcu_spi_responder against a frame-level model.
// Honours MCU_SPI_CRC_EN when defined for the build.
module tb_mcu_spi_responder;
    localparam int DATA_BYTES  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DW          = 8 * DATA_BYTES;
`ifdef MCU_SPI_CRC_EN
    localparam int NB = DATA_BYTES + 2;
`else
    localparam int NB = DATA_BYTES + 1;
`endif
    localparam int FULL = 8 * NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_sclk, spi_cs_n, spi_mosi, mcu_req;
    logic          mcu_ack, wr_valid, wr_ready, frame_err;
    logic [31:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    err_count;

    mcu_spi_responder #(
        .DATA_BYTES (DATA_BYTES),
        .SYNC_STAGES(SYNC_STAGES),
        .ADDR_BASE  (32'h0500_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .mcu_req  (mcu_req),
        .mcu_ack  (mcu_ack),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    int n_errp   = 0;
    int exp_err  = 0;
    logic [31:0]   cap_addr;
    logic [DW-1:0] cap_data;
    byte unsigned  tx_bytes[$];
    bit            tx_bits[$];

    always @(negedge clk) begin
        if (frame_err) n_errp++;
        if (wr_valid && wr_ready) begin
            n_xfer++;
            cap_addr = wr_addr;
            cap_data = wr_data;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, need %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic byte unsigned crc8(input int n);
        byte unsigned c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ tx_bytes[i];
            for (int b = 0; b < 8; b++)
                c = c[7] ? byte'((c << 1) ^ 8'h07) : byte'(c << 1);
        end
        return c;
    endfunction

    task automatic make_frame(input byte unsigned cmd, input logic [DW-1:0] data, input int extra);
        tx_bytes.delete();
        tx_bytes.push_back(cmd);
        for (int i = DATA_BYTES - 1; i >= 0; i--) tx_bytes.push_back(data[8*i +: 8]);
`ifdef MCU_SPI_CRC_EN
        tx_bytes.push_back(crc8(DATA_BYTES + 1));
`endif
        for (int i = 0; i < extra; i++) tx_bytes.push_back(8'($urandom));
    endtask

    function automatic void predict(input int nbits, output bit ok,
                                    output logic [31:0] ea, output logic [DW-1:0] ed);
        byte unsigned cmd = tx_bytes[0];
        ok = (nbits >= FULL) && cmd[7];
`ifdef MCU_SPI_CRC_EN
        ok = ok && (crc8(DATA_BYTES + 1) == tx_bytes[NB-1]);
`endif
        ea = 32'h0500_0000 + 32'(cmd & 8'h7F) * 4;
        ed = '0;
        for (int i = 1; i <= DATA_BYTES; i++) ed = (ed << 8) | DW'(tx_bytes[i]);
    endfunction

    task automatic shift_bits(input int from, input int to);
        for (int i = from; i < to; i++) begin
            spi_mosi = tx_bits[i];
            cyc(4);
            spi_sclk = 1'b1;
            cyc(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic build_bits(input int nbits);
        tx_bits.delete();
        foreach (tx_bytes[i])
            for (int b = 7; b >= 0; b--) tx_bits.push_back(tx_bytes[i][b]);
        while (tx_bits.size() > nbits) void'(tx_bits.pop_back());
    endtask

    task automatic arm(output int k);
        mcu_req = 1'b1;
        k = 0;
        while (!mcu_ack && k < 20) begin
            cyc(1);
            k++;
        end
        check("arm_ack", 64'(mcu_ack), 64'd1);
    endtask

    task automatic run_frame(input int nbits, input int stall);
        int            x0, e0, k;
        bit            ok;
        logic [31:0]   ea;
        logic [DW-1:0] ed;
        build_bits(nbits);
        predict(nbits, ok, ea, ed);
        x0 = n_xfer;
        e0 = n_errp;
        wr_ready = (stall == 0);
        spi_cs_n = 1'b0;
        cyc(4);
        shift_bits(0, tx_bits.size());
        cyc(4);
        spi_cs_n = 1'b1;
        if (ok) begin
            k = 0;
            while (!wr_valid && k < 20) begin
                cyc(1);
                k++;
            end
            check("wr_latency", 64'(k), 64'(SYNC_STAGES + 2));
            for (int i = 0; i < stall; i++) begin
                check("hold", {31'(wr_valid), wr_addr}, {31'd1, ea});
                check("hold_data", 64'(wr_data), 64'(ed));
                cyc(1);
            end
            wr_ready = 1'b1;
            cyc(2);
            wr_ready = 1'b0;
            check("xfer_count", 64'(n_xfer - x0), 64'd1);
            check("wr_addr", 64'(cap_addr), 64'(ea));
            check("wr_data", 64'(cap_data), 64'(ed));
            cyc(4);
            check("done_ack", 64'(mcu_ack), 64'd0);
            mcu_req = 1'b0;
            cyc(SYNC_STAGES + 3);
            arm(k);
        end else begin
            cyc(12);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            check("no_xfer", 64'(n_xfer - x0), 64'd0);
            check("err_pulse", 64'(n_errp - e0), 64'd1);
            check("err_count", 64'(err_count), 64'(exp_err));
            check("err_ack", 64'(mcu_ack), 64'd1);
        end
    endtask

    initial begin
        int k, kind, nb, stall, x0, e0;
        byte unsigned c;
        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        mcu_req = 1'b0;
        wr_ready = 1'b0;
        cyc(3);
        rst = 1'b0;
        check("rst_ack", 64'(mcu_ack), 64'd0);
        check("rst_valid", 64'(wr_valid), 64'd0);
        check("rst_ferr", 64'(frame_err), 64'd0);
        check("rst_errcnt", 64'(err_count), 64'd0);
        check("rst_addr", 64'(wr_addr), 64'd0);
        check("rst_data", 64'(wr_data), 64'd0);
        cyc(5);

        arm(k);
        check("arm_latency", 64'(k), 64'(SYNC_STAGES + 1));
        mcu_req = 1'b0;
        cyc(SYNC_STAGES + 2);
        check("disarm_ack", 64'(mcu_ack), 64'd0);
        arm(k);

        make_frame(8'h83, 32'hDEAD_BEEF, 0);
        run_frame(FULL, 0);
        make_frame(8'h83, 32'hDEAD_BEEF, 0);
        run_frame(FULL, 10);
        make_frame(8'h83, 32'hDEAD_BEEF, 0);
        run_frame(20, 0);
        make_frame(8'h05, 32'h1234_5678, 0);
        run_frame(FULL, 0);

`ifdef MCU_SPI_CRC_EN
        make_frame(8'h81, 32'h0000_0001, 0);
        run_frame(FULL, 0);
        tx_bytes[4] = tx_bytes[4] ^ 8'h01;
        run_frame(FULL, 0);
`endif

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 4);
            c = 8'($urandom);
            stall = $urandom_range(0, 6);
            nb = FULL;
            case (kind)
                1: c = c & 8'h7F;
                default: c = c | 8'h80;
            endcase
            make_frame(c, DW'($urandom), 2);
            if (kind == 2) nb = $urandom_range(1, FULL - 1);
            if (kind == 3) nb = FULL + $urandom_range(1, 15);
            if (kind == 4) begin
                k = $urandom_range(1, NB - 1);
                tx_bytes[k] = tx_bytes[k] ^ 8'(1 << $urandom_range(0, 7));
            end
            run_frame(nb, stall);
        end

        for (int f = 0; f < 260; f++) begin
            make_frame(8'h83, 32'h0, 0);
            run_frame(3, 0);
        end
        check("err_saturate", 64'(err_count), 64'd255);

        make_frame(8'h83, 32'hCAFE_F00D, 0);
        build_bits(FULL);
        x0 = n_xfer;
        spi_cs_n = 1'b0;
        cyc(4);
        shift_bits(0, 12);
        rst = 1'b1;
        #1;
        exp_err = 0;
        check("mid_rst_ack", 64'(mcu_ack), 64'd0);
        check("mid_rst_valid", 64'(wr_valid), 64'd0);
        check("mid_rst_errcnt", 64'(err_count), 64'd0);
        cyc(2);
        rst = 1'b0;
        e0 = n_errp;
        shift_bits(12, FULL);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(15);
        check("mid_rst_no_wr", 64'(n_xfer - x0), 64'd0);
        check("mid_rst_no_err", 64'(n_errp - e0), 64'd0);
        arm(k);
        make_frame(8'h8A, 32'h0BAD_CAFE, 0);
        run_frame(FULL, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
